instruction_fetch_unit: RTL

Fetches instruction words from instruction memory ahead of the processor core and buffers them in an in-order prefetch FIFO. It sits directly upstream of the core's decode, register-read and execute path and supplies each instruction with its PC. Memory access uses a request/response handshake. A redirect input from the core (taken branch, jump) flushes the buffer, discards stale in-flight responses and restarts fetching at the new PC.

---
 rtl/instruction_fetch_unit_if.sv | 31 +++
 rtl/instruction_fetch_unit.sv | 124 ++++++++++++
 2 files changed

// File: rtl/instruction_fetch_unit_if.sv
// Fetch-side handshake bundle: core redirect, instruction memory request/response,
// and the buffered instruction stream handed to decode.
interface instruction_fetch_unit_if;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        mem_request_valid;
  logic        mem_request_ready;
  logic [31:0] mem_request_address;
  logic        mem_response_valid;
  logic [31:0] mem_response_data;
  logic        instruction_valid;
  logic        instruction_ready;
  logic [31:0] instruction;
  logic [31:0] instruction_pc;

  modport master (
    input  redirect_valid, redirect_pc,
    input  mem_request_ready, mem_response_valid, mem_response_data,
    input  instruction_ready,
    output mem_request_valid, mem_request_address,
    output instruction_valid, instruction, instruction_pc
  );

  modport slave (
    output redirect_valid, redirect_pc,
    output mem_request_ready, mem_response_valid, mem_response_data,
    output instruction_ready,
    input  mem_request_valid, mem_request_address,
    input  instruction_valid, instruction, instruction_pc
  );
endinterface

// File: rtl/instruction_fetch_unit.sv
// Prefetching instruction fetch unit: issues in-order word fetches, buffers returned
// words with their PCs in a small FIFO, and flushes/restarts on a core redirect.
module instruction_fetch_unit #(
  parameter logic [31:0] RESET_PC   = 32'h8000_0000,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  instruction_fetch_unit_if.master bus
);
  localparam int unsigned     PTR_W   = $clog2(FIFO_DEPTH);
  localparam int unsigned     CNT_W   = PTR_W + 1;
  localparam logic [CNT_W:0]  DEPTH_L = (CNT_W + 1)'(FIFO_DEPTH);

  typedef enum logic {STREAM = 1'b0, DRAIN = 1'b1} state_e;

  state_e           state_q, state_d;
  logic [31:0]      fetch_pc_q, fetch_pc_d;
  logic [31:0]      resp_pc_q, resp_pc_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [CNT_W-1:0] in_flight_q, in_flight_d;
  logic [CNT_W-1:0] drop_q, drop_d;
  logic [31:0]      fifo_word_q [FIFO_DEPTH];
  logic [31:0]      fifo_pc_q   [FIFO_DEPTH];

  logic        credit_ok;
  logic        req_valid;
  logic        req_fire;
  logic        resp_ok;
  logic        head_valid;
  logic        push;
  logic        pop;
  logic [31:0] redirect_target;

  // Credits cover both buffered entries and requests still in flight, so a push never overflows.
  always_comb begin
    credit_ok       = ({1'b0, in_flight_q} + {1'b0, count_q}) < DEPTH_L;
    req_valid       = rst_n && !bus.redirect_valid && credit_ok;
    req_fire        = req_valid && bus.mem_request_ready;
    resp_ok         = bus.mem_response_valid && (in_flight_q != '0);
    head_valid      = rst_n && (count_q != '0);
    redirect_target = bus.redirect_pc & ~32'h3;
    push            = resp_ok && !bus.redirect_valid && (state_q == STREAM);
    pop             = head_valid && bus.instruction_ready && !bus.redirect_valid;

    bus.mem_request_valid   = req_valid;
    bus.mem_request_address = fetch_pc_q;
    bus.instruction_valid   = head_valid;
    bus.instruction         = head_valid ? fifo_word_q[rd_ptr_q] : '0;
    bus.instruction_pc      = head_valid ? fifo_pc_q[rd_ptr_q]   : '0;
  end

  always_comb begin
    state_d     = state_q;
    fetch_pc_d  = fetch_pc_q;
    resp_pc_d   = resp_pc_q;
    rd_ptr_d    = rd_ptr_q;
    wr_ptr_d    = wr_ptr_q;
    count_d     = count_q;
    in_flight_d = in_flight_q + CNT_W'(req_fire) - CNT_W'(resp_ok);
    drop_d      = drop_q;

    if (bus.redirect_valid) begin
      // Everything still owed by memory belongs to the old stream and must be discarded.
      fetch_pc_d = redirect_target;
      resp_pc_d  = redirect_target;
      rd_ptr_d   = '0;
      wr_ptr_d   = '0;
      count_d    = '0;
      drop_d     = in_flight_q - CNT_W'(resp_ok);
      state_d    = (drop_d != '0) ? DRAIN : STREAM;
    end else begin
      if (req_fire) begin
        fetch_pc_d = fetch_pc_q + 32'd4;
      end
      if (resp_ok && (state_q == DRAIN)) begin
        drop_d = drop_q - CNT_W'(1);
        if (drop_d == '0) begin
          state_d = STREAM;
        end
      end
      if (push) begin
        wr_ptr_d  = wr_ptr_q + PTR_W'(1);
        resp_pc_d = resp_pc_q + 32'd4;
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
      count_d = count_q + CNT_W'(push) - CNT_W'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= STREAM;
      fetch_pc_q  <= RESET_PC;
      resp_pc_q   <= RESET_PC;
      rd_ptr_q    <= '0;
      wr_ptr_q    <= '0;
      count_q     <= '0;
      in_flight_q <= '0;
      drop_q      <= '0;
    end else begin
      state_q     <= state_d;
      fetch_pc_q  <= fetch_pc_d;
      resp_pc_q   <= resp_pc_d;
      rd_ptr_q    <= rd_ptr_d;
      wr_ptr_q    <= wr_ptr_d;
      count_q     <= count_d;
      in_flight_q <= in_flight_d;
      drop_q      <= drop_d;
    end
  end

  // Payload storage is never reset; the occupancy count alone decides what is visible.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_word_q[wr_ptr_q] <= bus.mem_response_data;
      fifo_pc_q[wr_ptr_q]   <= resp_pc_q;
    end
  end
endmodule
